// File: rtl/mont_arbiter_pkg.sv
// mont_arbiter_pkg: shared state encoding and default operand width for the
// two-requester Montgomery multiplier arbiter.
package mont_arbiter_pkg;
  localparam int WIDTH_DEF = 1024;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;
endpackage

// File: rtl/mont_arbiter.sv
// mont_arbiter: round-robin arbiter sharing one external modular multiplier
// between two requesters; captures operands at grant, returns done/result.
module mont_arbiter
  import mont_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] m,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             owner,
  output logic             mul_rstn,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_m,
  input  logic [WIDTH-1:0] mul_res,
  input  logic             mul_done
);
  state_t           r_state, w_next;
  logic             r_owner, r_last;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic             w_req, w_win;

  assign w_req = req0 | req1;
  // Under contention the requester that was not granted last time wins.
  assign w_win = (req0 & req1) ? ~r_last : req1;

  always_comb begin
    w_next    = r_state;
    busy      = r_state != S_IDLE;
    mul_start = r_state == S_LOAD;
    mul_rstn  = r_state == S_LOAD || r_state == S_WAIT;
    done0     = r_state == S_RESP && !r_owner;
    done1     = r_state == S_RESP && r_owner;
    w_next    = r_state == S_IDLE ? (w_req ? S_LOAD : S_IDLE) :
                r_state == S_LOAD ? S_WAIT :
                r_state == S_WAIT ? (mul_done ? S_RESP : S_WAIT) : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_a     <= w_win ? a1 : a0;
        r_b     <= w_win ? b1 : b0;
      end
      if (r_state == S_WAIT && mul_done) r_result <= mul_res;
    end
  end

  assign result = r_result;
  assign owner  = r_owner;
  assign mul_a  = r_a;
  assign mul_b  = r_b;
  assign mul_m  = m;
endmodule

// File: tb/tb_mont_arbiter.sv
// tb_mont_arbiter: directed and randomized checks of mont_arbiter against a
// timestamp-based behavioural model, with a delayed-done multiplier stub.
module tb_mont_arbiter;
  localparam int W = 1024;

  logic         clk = 1'b0;
  logic         resetn, req0, req1, done0, done1, busy, owner;
  logic         mul_rstn, mul_start, mul_done;
  logic [W-1:0] a0, b0, a1, b1, m, result, mul_a, mul_b, mul_m, mul_res;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  mont_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .m(m),
    .done0(done0), .done1(done1), .result(result), .busy(busy), .owner(owner),
    .mul_rstn(mul_rstn), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_m(mul_m), .mul_res(mul_res), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] modmul(logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] z);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    p = p % {{W{1'b0}}, z};
    return p[W-1:0];
  endfunction

  task automatic chk_i(string nm, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_w(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h (low 64 bits, cycle %0d)", nm, act[63:0], exp[63:0], cyc);
    end
  endtask

  // Multiplier stub: done pulse stub_n cycles after start, optional spurious done in LOAD.
  int           stub_n = 10;
  logic         early = 1'b0;
  int           cnt;
  logic         r_md;
  logic [W-1:0] r_res;

  always @(posedge clk) begin
    r_md <= 1'b0;
    if (!resetn || !mul_rstn) cnt <= 0;
    else if (mul_start) begin
      cnt   <= stub_n - 1;
      r_res <= modmul(mul_a, mul_b, mul_m);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) r_md <= 1'b1;
    end
  end

  assign mul_done = r_md | (early & mul_start);
  assign mul_res  = r_res;

  // Behavioural model: remembers grant cycle and done cycle of the current operation.
  logic         mv = 1'b0, mb, mo, ml;
  logic [W-1:0] ma, mbb, mres;
  int           st, dc;

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      mv = 1'b1; mb = 1'b0; mo = 1'b0; ml = 1'b1; mres = '0; st = -1; dc = -1;
    end else if (mv) begin
      if (!mb) begin
        if (req0 || req1) begin
          mo  = (req0 && req1) ? !ml : req1;
          ml  = mo;
          ma  = mo ? a1 : a0;
          mbb = mo ? b1 : b0;
          mb  = 1'b1;
          st  = cyc;
          dc  = -1;
        end
      end else if (cyc - 1 == dc) mb = 1'b0;
      else if (cyc - 1 > st && dc < 0 && mul_done) begin
        mres = modmul(ma, mbb, m);
        dc   = cyc;
      end
    end
  end

  logic       e_done;
  logic [5:0] e_ctrl;

  always @(negedge clk) if (mv) begin
    e_done = mb && cyc == dc;
    e_ctrl = {mb, mb && cyc == st, mb && !e_done, e_done && !mo, e_done && mo, mo};
    chk_i("ctrl{busy,start,rstn,done0,done1,owner}",
          int'({busy, mul_start, mul_rstn, done0, done1, owner}), int'(e_ctrl));
    chk_w("result", result, mres);
    chk_w("mul_m", mul_m, m);
    if (mb) begin
      chk_w("mul_a", mul_a, ma);
      chk_w("mul_b", mul_b, mbb);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int ts, td0, td1, n0, n1, g;
  int gq[$];

  // Runs n cycles; requesters drop their request on their done unless hold is set.
  task automatic run_op(int n, bit hold);
    ts = -1; td0 = -1; td1 = -1; n0 = 0; n1 = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (mul_start) begin
        if (ts < 0) ts = cyc;
        gq.push_back(int'(owner));
      end
      if (done0) begin
        if (td0 < 0) td0 = cyc;
        n0++;
        if (!hold) req0 = 1'b0;
      end
      if (done1) begin
        if (td1 < 0) td1 = cyc;
        n1++;
        if (!hold) req1 = 1'b0;
      end
    end
  endtask

  function automatic int gq_at(int i);
    return gq.size() > i ? gq[i] : -1;
  endfunction

  initial begin
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; m = W'(13);
    repeat (2) step();
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_owner", int'(owner), 0);
    chk_i("rst_start", int'(mul_start), 0);
    chk_i("rst_rstn", int'(mul_rstn), 0);
    chk_i("rst_done", int'({done0, done1}), 0);
    chk_w("rst_result", result, '0);
    resetn = 1'b1;
    step();

    // Single request 5*7 mod 13, N=10
    a0 = W'(5); b0 = W'(7); req0 = 1'b1; g = cyc + 1;
    run_op(30, 1'b0);
    chk_i("t1_start_cycle", ts, g);
    chk_i("t1_done0_cycle", td0, g + 11);
    chk_i("t1_done0_count", n0, 1);
    chk_i("t1_done1_count", n1, 0);
    chk_w("t1_result", result, W'(9));

    // Operand change after grant is ignored
    a0 = W'(5); b0 = W'(7); req0 = 1'b1;
    step(); g = cyc;
    repeat (2) step();
    a0 = W'(3);
    step();
    chk_w("t3_mul_a", mul_a, W'(5));
    run_op(30, 1'b0);
    chk_i("t3_done0_count", n0, 1);
    chk_w("t3_result", result, W'(9));

    // Spurious done in LOAD, real done at N=6: 4*5 mod 13 = 7
    early = 1'b1; stub_n = 6; a0 = W'(4); b0 = W'(5); req0 = 1'b1; g = cyc + 1;
    run_op(25, 1'b0);
    early = 1'b0;
    chk_i("t4_done0_count", n0, 1);
    chk_i("t4_done0_cycle", td0, g + 7);
    chk_w("t4_result", result, W'(7));

    // Reset in WAIT cycle 4 aborts silently
    stub_n = 10; a0 = W'(5); b0 = W'(7); req0 = 1'b1;
    step(); g = cyc;
    repeat (4) step();
    resetn = 1'b0; req0 = 1'b0;
    step();
    resetn = 1'b1;
    chk_i("t5_mul_rstn", int'(mul_rstn), 0);
    chk_i("t5_busy", int'(busy), 0);
    chk_w("t5_result", result, '0);
    run_op(20, 1'b0);
    chk_i("t5_no_done", n0 + n1, 0);
    chk_i("t5_no_start", ts, -1);

    // Contention after reset: req0 first, then req1
    stub_n = 4; a0 = W'(2); b0 = W'(3); a1 = W'(4); b1 = W'(5);
    req0 = 1'b1; req1 = 1'b1; gq.delete();
    run_op(40, 1'b0);
    chk_i("t2_grants", gq.size(), 2);
    chk_i("t2_grant0", gq_at(0), 0);
    chk_i("t2_grant1", gq_at(1), 1);
    chk_i("t2_done_order", int'(td0 >= 0 && td0 < td1), 1);
    chk_i("t2_done_counts", n0 * 10 + n1, 11);
    chk_w("t2_result", result, W'(7));

    // Both held continuously: strict alternation
    stub_n = 3; req0 = 1'b1; req1 = 1'b1; gq.delete();
    run_op(30, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) chk_i($sformatf("t6_grant%0d", i), gq_at(i), i % 2);
    repeat (15) step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      resetn = 1'b1;
      if (done0) req0 = 1'b0;
      else if (!req0 && $urandom_range(3) == 0) begin
        req0 = 1'b1; a0 = W'($urandom); b0 = W'($urandom);
      end
      if (done1) req1 = 1'b0;
      else if (!req1 && $urandom_range(3) == 0) begin
        req1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom);
      end
      if ($urandom_range(7) == 0) a0 = W'($urandom);
      if ($urandom_range(7) == 0) b1 = W'($urandom);
      if (!busy && $urandom_range(9) == 0) m = W'($urandom_range(32'h7fffffff, 1));
      if ($urandom_range(15) == 0) stub_n = int'($urandom_range(8, 2));
      early = $urandom_range(1) == 1;
      if ($urandom_range(399) == 0) begin
        resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0; early = 1'b0;
    repeat (20) step();
    chk_i("final_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
